ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
Pipeline sequencing controller for the EX stage of the 5-stage MIPS core. It detects load-use hazards, sequences multi-cycle MUL occupancy of the EX ALU, flushes IF/ID and ID/EX on a taken branch resolved in EX, and drives the EX operand forwarding selects. Its outputs gate the PC, IF/ID and ID/EX pipeline registers.

Parameters:
MUL_CYCLES, 4, total cycles a MUL occupies EX (legal range 2..15)
CNT_W, 16, width of the saturating stall-cycle performance counter

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
id_rs  input  5  source reg A of instruction in ID
id_rt  input  5  source reg B of instruction in ID
id_uses_rt  input  1  ID instruction reads rt
ex_valid  input  1  EX holds a real (non-bubble) instruction
ex_rs  input  5  source reg A of instruction in EX
ex_rt  input  5  source reg B of instruction in EX
ex_rd  input  5  destination reg of EX instruction (after RegDst mux)
ex_mem_read  input  1  EX instruction is LW
ex_is_mul  input  1  EX instruction is MUL (RR_ALU, func 000101)
ex_branch_taken  input  1  EX branch resolved taken (branch op and ZERO)
mem_rd  input  5  destination reg in EX/MEM
mem_reg_write  input  1  EX/MEM writes register file
wb_rd  input  5  destination reg in MEM/WB
wb_reg_write  input  1  MEM/WB writes register file
pc_write  output  1  PC load enable
if_id_write  output  1  IF/ID load enable
if_id_flush  output  1  clear IF/ID to bubble
id_ex_bubble  output  1  load bubble (all control zero) into ID/EX
ex_hold  output  1  ID/EX and EX inputs held (MUL in progress)
fwd_a  output  2  operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  output  2  operand B select, same encoding
mul_busy  output  1  state is MUL_WAIT
stall_count  output  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- State register: RUN, MUL_WAIT; counter mul_cnt (4 bits). All state on posedge clk, cleared asynchronously when rst_n=0.
- Reset values: state RUN, mul_cnt 0, stall_count 0; with idle inputs outputs are pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, ex_hold=0, fwd_a=fwd_b=00, mul_busy=0.
- Control outputs are combinational from state and current inputs (zero latency); only state, mul_cnt and stall_count are registered.
- Priority in RUN, highest first: branch, MUL, load-use.
- Branch: ex_valid & ex_branch_taken -> if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; state stays RUN. Masks a simultaneous load-use hazard.
- MUL start: RUN & ex_valid & ex_is_mul -> pc_write=0, if_id_write=0, ex_hold=1. Next state MUL_WAIT, mul_cnt<=MUL_CYCLES-2.
- MUL_WAIT, mul_cnt!=0: pc_write=0, if_id_write=0, ex_hold=1, mul_busy=1; mul_cnt decrements.
- MUL_WAIT, mul_cnt==0: mul_busy=1, ex_hold=0, pc_write=1, if_id_write=1; next state RUN. Total EX occupancy is MUL_CYCLES cycles, with MUL_CYCLES-1 stalled cycles.
- MUL_WAIT ignores ex_branch_taken and load-use inputs.
- Load-use: RUN, no branch, no MUL start, ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)) -> pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle. The next cycle the LW has moved to MEM, so the hazard clears.
- Forwarding for fwd_a (fwd_b identical using ex_rt):
  - 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs.
  - else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs.
  - else 00.
  - Computed in all states; EX/MEM wins over MEM/WB.
- stall_count: increments each cycle pc_write=0; saturates at all-ones, no wrap.
- rst_n asserted mid-MUL_WAIT: immediate return to RUN, mul_cnt=0, outputs at reset values.
- Register 0 never triggers a hazard or forwarding.

Test Plan:
- Reset with rst_n=0 mid MUL_WAIT (mul_cnt=1) -> state RUN, mul_busy=0, pc_write=1, stall_count=0 immediately, without waiting for a clock.
- LW in EX with ex_rd=5, id_rs=5 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1. Repeat with ex_rd=0 -> no stall.
- MUL in EX, MUL_CYCLES=4 -> ex_hold=1 for 3 cycles, mul_busy=1 for cycles 2-4, pc_write returns to 1 on cycle 4, stall_count=3.
- ex_branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_bubble=1, pc_write=1, stall_count unchanged.
- mem_rd=wb_rd=7 both writing, ex_rs=7, ex_rt=7 -> fwd_a=fwd_b=10. Then mem_reg_write=0 -> 01. Then wb_rd=0 -> 00.
- Force a stall every cycle with CNT_W=4 -> stall_count reaches 15 and holds at 15.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// EX-stage pipeline sequencing controller: load-use stall, multi-cycle MUL
// occupancy, taken-branch flush, operand forwarding selects and a saturating
// stall-cycle counter.
module ex_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_is_mul,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] MUL_RELOAD = 4'(MUL_CYCLES - 2);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_mul_cnt, w_mul_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_branch, w_mul_start, w_load_use;

  assign w_branch    = ex_valid & ex_branch_taken;
  assign w_mul_start = ex_valid & ex_is_mul;
  assign w_load_use  = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                       ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  // State and MUL countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_mul_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
    end
  end

  // Next state and pipeline control outputs; branch > MUL > load-use in RUN
  always_comb begin
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_hold       = 1'b0;
    mul_busy      = 1'b0;
    case (r_state)
      RUN: begin
        if (w_branch) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (w_mul_start) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_hold       = 1'b1;
          w_state_nxt   = MUL_WAIT;
          w_mul_cnt_nxt = MUL_RELOAD;
        end else if (w_load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MUL_WAIT: begin
        mul_busy = 1'b1;
        if (r_mul_cnt != 4'd0) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_hold       = 1'b1;
          w_mul_cnt_nxt = r_mul_cnt - 4'd1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Forwarding selects: EX/MEM result wins over MEM/WB, r0 never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs)
      fwd_a = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs)
      fwd_a = 2'b01;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rt)
      fwd_b = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rt)
      fwd_b = 2'b01;
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (!pc_write && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: a vector table for the combinational
// control/forwarding decode plus hand sequences for MUL, reset and saturation.
module tb_ex_hazard_ctrl;

  logic       clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rt, ex_valid, ex_mem_read, ex_is_mul, ex_branch_taken;
  logic       mem_reg_write, wb_reg_write;

  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mul_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_ex_hold, s_mul_busy;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_count;

  int total = 0;
  int bad   = 0;

  ex_hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mul_busy(mul_busy), .stall_count(stall_count)
  );

  ex_hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_is_mul(ex_is_mul), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .ex_hold(s_ex_hold), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .mul_busy(s_mul_busy), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mul_busy, fwd_a, fwd_b}
  typedef struct {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rt;
    logic       valid;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic       mrd;
    logic       br;
    logic [4:0] mem_rd;
    logic       mem_we;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic [9:0] exp;
  } vec_t;

  localparam logic [9:0] E_IDLE = 10'b11_0000_00_00;
  localparam logic [9:0] E_LU   = 10'b00_0100_00_00;
  localparam logic [9:0] E_BR   = 10'b11_1100_00_00;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic logic [9:0] act_vec();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mul_busy, fwd_a, fwd_b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_valid = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_mem_read = 1'b0; ex_is_mul = 1'b0;
    ex_branch_taken = 1'b0; mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rt = v.uses_rt; ex_valid = v.valid;
    ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_rd = v.ex_rd; ex_mem_read = v.mrd;
    ex_is_mul = 1'b0; ex_branch_taken = v.br; mem_rd = v.mem_rd; mem_reg_write = v.mem_we;
    wb_rd = v.wb_rd; wb_reg_write = v.wb_we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // id_rs id_rt urt val ex_rs ex_rt ex_rd mrd br mem_rd mwe wb_rd wwe exp
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, E_IDLE};
    vecs[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, E_LU};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, E_IDLE};
    vecs[3]  = '{5'd1, 5'd6, 1'b1, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, E_LU};
    vecs[4]  = '{5'd1, 5'd6, 1'b0, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, E_IDLE};
    vecs[5]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, E_IDLE};
    vecs[6]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, E_BR};
    vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, E_IDLE};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 10'b11_0000_10_10};
    vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 10'b11_0000_01_01};
    vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 5'd0, 1'b1, E_IDLE};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 10'b11_0000_10_01};
    vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, E_IDLE};
    vecs[13] = '{5'd2, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, E_LU};

    idle();
    rst_n = 1'b0;
    #12;
    chk("reset_outputs", {22'd0, act_vec()}, {22'd0, E_IDLE});
    chk("reset_stall_count", {16'd0, stall_count}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d", i), {22'd0, act_vec()}, {22'd0, vecs[i].exp});
      tick();
    end
    idle();
    #1;
    // vectors 1, 3 and 13 each stall one cycle; the branch vector does not
    chk("stall_count_after_table", {16'd0, stall_count}, 32'd3);

    // MUL occupancy: 3 held cycles, busy in cycles 2..4, release on cycle 4
    ex_valid = 1'b1; ex_is_mul = 1'b1;
    #1;
    chk("mul_c1", {22'd0, act_vec()}, {22'd0, 10'b00_0010_00_00});
    tick();
    // branch and load-use presented mid-MUL are ignored
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    #1;
    chk("mul_c2_ignore", {22'd0, act_vec()}, {22'd0, 10'b00_0011_00_00});
    tick();
    ex_branch_taken = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    chk("mul_c3", {22'd0, act_vec()}, {22'd0, 10'b00_0011_00_00});
    tick();
    chk("mul_c4", {22'd0, act_vec()}, {22'd0, 10'b11_0001_00_00});
    tick();
    idle();
    #1;
    chk("mul_c5_run", {22'd0, act_vec()}, {22'd0, E_IDLE});
    chk("mul_stall_count", {16'd0, stall_count}, 32'd6);

    // asynchronous reset while in MUL_WAIT with one wait cycle left
    ex_valid = 1'b1; ex_is_mul = 1'b1;
    tick();
    tick();
    chk("pre_reset_busy", {31'd0, mul_busy}, 32'd1);
    #2;
    idle();
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {22'd0, act_vec()}, {22'd0, E_IDLE});
    chk("async_reset_count", {16'd0, stall_count}, 32'd0);
    chk("async_reset_count4", {28'd0, s_stall_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_reset_run", {22'd0, act_vec()}, {22'd0, E_IDLE});

    // continuous load-use stall to exercise saturation of the 4-bit counter
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs = 5'd12;
    for (int c = 0; c < 14; c++) tick();
    chk("sat_count4_14", {28'd0, s_stall_count}, 32'd14);
    tick();
    chk("sat_count4_15", {28'd0, s_stall_count}, 32'd15);
    for (int c = 0; c < 5; c++) tick();
    chk("sat_count4_hold", {28'd0, s_stall_count}, 32'd15);
    chk("count16_20", {16'd0, stall_count}, 32'd20);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
